// File: rtl/conv1_out_mem_write.sv
`default_nettype none
// ============================================================================
// Module   : conv1_out_mem_write
// Purpose  : Write-side addresser for the conv1 output feature-map memory.
//            Accepts one channel-0/channel-1 result pair per handshake and
//            writes it one cycle later: channel 0 at idx, channel 1 at
//            CH1_BASE+idx. Raises done once the full map has been written.
// Revision : 1.0  initial release
// ============================================================================
module conv1_out_mem_write #(
  parameter int OUT_W    = 24,
  parameter int OUT_H    = 24,
  parameter int CH1_BASE = 576,
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  output logic              we0,
  output logic              we1,
  output logic [ADDR_W-1:0] addr0,
  output logic [ADDR_W-1:0] addr1,
  output logic [DATA_W-1:0] wdata0,
  output logic [DATA_W-1:0] wdata1,
  output logic [4:0]        row,
  output logic [4:0]        col,
  output logic              done
);

  localparam int NPIX  = OUT_W * OUT_H;
  localparam int IDX_W = $clog2(NPIX);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NPIX - 1);
  localparam logic [4:0]        LAST_COL = 5'(OUT_W - 1);
  localparam logic [ADDR_W-1:0] CH1_OFS  = ADDR_W'(CH1_BASE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             last_pix;
  logic             clear_cnt;

  // Ready only while writing and not paused; accept is the handshake.
  assign in_ready = (state == S_WRITE) && enable;
  assign accept   = in_valid && in_ready;
  assign last_pix = (idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; start only matters in IDLE and DONE.
  always_comb begin
    next_state = state;
    clear_cnt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_WRITE;
          clear_cnt  = 1'b1;
        end
      end
      S_WRITE: begin
        if (accept && last_pix) begin
          next_state = S_FLUSH;
        end
      end
      S_FLUSH: begin
        next_state = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          next_state = S_WRITE;
          clear_cnt  = 1'b1;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Pixel position counters; they stop on the last pixel instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
      row <= '0;
      col <= '0;
    end else if (clear_cnt) begin
      idx <= '0;
      row <= '0;
      col <= '0;
    end else if (accept && !last_pix) begin
      idx <= idx + 1'b1;
      if (col == LAST_COL) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Memory write port: one-cycle strobe per accept, address/data hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we0    <= 1'b0;
      we1    <= 1'b0;
      addr0  <= '0;
      addr1  <= CH1_OFS;
      wdata0 <= '0;
      wdata1 <= '0;
    end else begin
      we0 <= accept;
      we1 <= accept;
      if (accept) begin
        addr0  <= ADDR_W'(idx);
        addr1  <= CH1_OFS + ADDR_W'(idx);
        wdata0 <= in_data0;
        wdata1 <= in_data1;
      end
    end
  end

  // Completion level: set on entry to DONE, cleared when a new map starts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done <= 1'b0;
    end else begin
      done <= (next_state == S_DONE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv1_out_mem_write.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv1_out_mem_write
// Purpose  : Scoreboard bench for conv1_out_mem_write. A pixel-count model
//            predicts handshakes and queues the expected writes; a monitor
//            pops and compares every write strobe seen on the memory port.
// Revision : 1.0  initial release
// ============================================================================
module tb_conv1_out_mem_write;

  localparam int NPIX = 576;
  localparam int BASE = 576;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data0;
  logic [15:0] in_data1;
  logic        we0;
  logic        we1;
  logic [10:0] addr0;
  logic [10:0] addr1;
  logic [15:0] wdata0;
  logic [15:0] wdata1;
  logic [4:0]  row;
  logic [4:0]  col;
  logic        done;

  conv1_out_mem_write dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .enable   (enable),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data0 (in_data0),
    .in_data1 (in_data1),
    .we0      (we0),
    .we1      (we1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .row      (row),
    .col      (col),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          a0;
    int          a1;
    logic [15:0] d0;
    logic [15:0] d1;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem  [0:2*NPIX-1];
  logic [15:0] emem [0:2*NPIX-1];
  int          vectors     = 0;
  int          miscompares = 0;
  int          n_we        = 0;
  // Reference model: 0 idle, 1 writing, 2 flushing, 3 done; m_cnt = pixels accepted.
  int          m_state     = 0;
  int          m_cnt       = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && (we0 === 1'b1 || we1 === 1'b1)) begin
      exp_t e;
      n_we++;
      chk("we_pair", {31'd0, we0 & we1}, 32'd1);
      if (sb.size() == 0) begin
        chk("unexpected_we", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("addr0", 32'(addr0), e.a0);
        chk("addr1", 32'(addr1), e.a1);
        chk("wdata0", 32'(wdata0), 32'(e.d0));
        chk("wdata1", 32'(wdata1), 32'(e.d1));
        if (addr0 < 11'(2*NPIX)) mem[addr0] = wdata0;
        if (addr1 < 11'(2*NPIX)) mem[addr1] = wdata1;
      end
    end
  end

  // One clock of stimulus; checks handshake/status and advances the model.
  task automatic step(input bit v, input bit en, input bit st, input bit seq);
    logic [15:0] d0;
    logic [15:0] d1;
    int          pos;
    bit          acc;
    if (seq) begin
      d0 = 16'(m_cnt);
      d1 = ~d0;
    end else begin
      d0 = 16'($urandom);
      d1 = 16'($urandom);
    end
    in_valid = v;
    enable   = en;
    start    = st;
    in_data0 = d0;
    in_data1 = d1;
    @(negedge clk);
    pos = (m_cnt > NPIX-1) ? NPIX-1 : m_cnt;
    chk("in_ready", {31'd0, in_ready}, {31'd0, (m_state == 1) && en});
    chk("done", {31'd0, done}, {31'd0, m_state == 3});
    chk("row", 32'(row), pos / 24);
    chk("col", 32'(col), pos % 24);
    acc = v && (m_state == 1) && en;
    if (acc) begin
      sb.push_back('{m_cnt, BASE + m_cnt, d0, d1});
      emem[m_cnt]        = d0;
      emem[BASE + m_cnt] = d1;
      m_cnt++;
    end
    case (m_state)
      0, 3: if (st) begin m_state = 1; m_cnt = 0; end
      1:    if (m_cnt == NPIX) m_state = 2;
      2:    m_state = 3;
      default: m_state = 0;
    endcase
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit st_p;
    bit gap_done;
    int w0;

    reset = 1'b0; start = 1'b0; enable = 1'b0; in_valid = 1'b0;
    in_data0 = '0; in_data1 = '0;
    for (int i = 0; i < 2*NPIX; i++) begin mem[i] = '0; emem[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we0", {31'd0, we0}, 32'd0);
    chk("rst_we1", {31'd0, we1}, 32'd0);
    chk("rst_addr0", 32'(addr0), 32'd0);
    chk("rst_addr1", 32'(addr1), BASE);
    chk("rst_wdata0", 32'(wdata0), 32'd0);
    chk("rst_wdata1", 32'(wdata1), 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b1;

    // Idle cycles with in_valid high must not be accepted.
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);

    // Full map, streaming; ignored start at #50, 5-cycle pause after #100.
    w0 = n_we;
    gap_done = 1'b0;
    step(1, 1, 1, 0);
    for (int i = 0; i < 3000 && m_cnt < NPIX; i++) begin
      if (m_cnt == 100 && !gap_done) begin
        repeat (5) step(1, 0, 0, 0);
        gap_done = 1'b1;
      end
      st_p = (m_cnt == 50);
      step(1, 1, st_p, 0);
    end
    chk("accepts_run1", m_cnt, NPIX);
    repeat (3) step(1, 1, 0, 0);
    chk("we_total_run1", n_we - w0, NPIX);
    chk("sb_empty_run1", sb.size(), 0);

    // Sparse valid with index-coded data, random pauses; restart from DONE.
    for (int i = 0; i < 2*NPIX; i++) begin mem[i] = '0; emem[i] = '0; end
    step(0, 1, 1, 0);
    for (int i = 0; i < 5000 && m_cnt < NPIX; i++) begin
      step((i % 3) == 0, $urandom_range(0, 7) != 0, 0, 1);
    end
    chk("accepts_run2", m_cnt, NPIX);
    repeat (3) step(0, 1, 0, 0);
    for (int i = 0; i < 2*NPIX; i++) begin
      chk("mem", 32'(mem[i]), 32'(emem[i]));
    end

    // Abort a map at accept #300 with an asynchronous reset.
    step(0, 1, 1, 0);
    for (int i = 0; i < 3000 && m_cnt < 300; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 0, 0);
    end
    chk("accepts_run3", m_cnt, 300);
    reset = 1'b0;
    #1;
    chk("arst_we0", {31'd0, we0}, 32'd0);
    chk("arst_we1", {31'd0, we1}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_addr0", 32'(addr0), 32'd0);
    chk("arst_addr1", 32'(addr1), BASE);
    chk("arst_row", 32'(row), 32'd0);
    chk("arst_col", 32'(col), 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd0);
    sb.delete();
    m_state = 0;
    m_cnt   = 0;
    #1;
    reset = 1'b1;
    step(1, 1, 0, 0);

    // Fresh map after the abort.
    w0 = n_we;
    step(0, 1, 1, 0);
    for (int i = 0; i < 3000 && m_cnt < NPIX; i++) begin
      step($urandom_range(0, 1) == 1, 1, 0, 0);
    end
    chk("accepts_run4", m_cnt, NPIX);
    repeat (3) step(0, 1, 1'b0, 0);
    chk("we_total_run4", n_we - w0, NPIX);
    chk("sb_empty_run4", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv1_out_mem_write.md
Name: conv1_out_mem_write

Overview:
Counter/addresser for the Convolution 1 layer output feature-map memory write. It is the write-side counterpart of the conv1 weight-memory read addresser. It accepts one result pair per handshake from the conv1 datapath (channel 0 and channel 1 pixels for the same output position) and writes the pair into the shared conv1 output memory: channel 0 at offset 0, channel 1 at offset CH1_BASE. Done flags completion of the full 24x24 map for the pool1 stage.

Parameters:
OUT_W, 24, output feature-map width (pixels per row)
OUT_H, 24, output feature-map height (rows)
CH1_BASE, 576, address offset of channel 1 region (= OUT_W*OUT_H)
ADDR_W, 11, write address width (covers 2*OUT_W*OUT_H words)
DATA_W, 16, result word width

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  one-cycle pulse, begins a map write from IDLE or DONE
enable  input  1  1 = may accept results; 0 = pause, all counters hold
in_valid  input  1  conv1 datapath has a result pair
in_ready  output  1  block accepts a pair this cycle
in_data0  input  DATA_W  channel 0 result
in_data1  input  DATA_W  channel 1 result
we0  output  1  write strobe, channel 0 port
we1  output  1  write strobe, channel 1 port
addr0  output  ADDR_W  channel 0 write address
addr1  output  ADDR_W  channel 1 write address
wdata0  output  DATA_W  channel 0 write data
wdata1  output  DATA_W  channel 1 write data
row  output  5  row of next pixel to accept
col  output  5  column of next pixel to accept
done  output  1  level, full map written

Behaviour:
- Reset (reset=0, async): state=IDLE; row=col=0; pixel index idx=0; addr0=0; addr1=CH1_BASE; we0=we1=0; wdata0=wdata1=0; done=0.
- FSM states: IDLE, WRITE, FLUSH, DONE.
- IDLE: in_ready=0. start=1 -> WRITE; idx, row, col cleared.
- WRITE: in_ready = enable (combinational from state and enable). Accept = in_valid & in_ready.
- On accept, the next edge registers addr0=idx, addr1=CH1_BASE+idx, wdata0/1=in_data0/1, and we0=we1=1. Write latency is 1 cycle from accept; we0/we1 are high for exactly one cycle per accept.
- Without accept: we0=we1=0. addr/wdata hold their last values.
- Counters on accept: idx+1. col+1; when col==OUT_W-1, col wraps to 0 and row increments.
- Accept of the last pixel (idx==OUT_W*OUT_H-1, row=OUT_H-1, col=OUT_W-1) -> FLUSH. row/col/idx do not wrap; they hold the last values.
- FLUSH: lasts one cycle, during which the final we pulse is issued. in_ready=0. Then -> DONE.
- DONE: done=1 (registered), in_ready=0. done first goes high 2 cycles after the final accept and holds until start or reset.
- start in DONE -> WRITE. done drops the next cycle; counters clear.
- start in WRITE or FLUSH: ignored.
- enable=0 in WRITE: in_ready=0; counters, addresses and state hold; no writes. Resumes seamlessly when enable=1.
- in_valid while in_ready=0: ignored, no side effects.
- Address arithmetic: unsigned, ADDR_W bits. Max addr1 = CH1_BASE+575 = 1151, which fits in 11 bits.
- Reset mid-operation: immediate return to reset values. A partially written map is abandoned, and no we pulse is issued after reset asserts.

Test Plan:
- Reset then start, with in_valid held 1 and enable 1 -> 576 accepts on consecutive cycles. First write: addr0=0, addr1=576. Last write: addr0=575, addr1=1151. done rises 2 cycles after the 576th accept, total we pulses = 576.
- Row wrap: after 24 accepts -> row=1, col=0. 25th write uses addr0=24, addr1=600.
- Backpressure: drop enable for 5 cycles after accept #100 -> in_ready=0 and no we during the gap. Accept #101 writes addr0=100; total count remains 576.
- Sparse in_valid (1 every 3 cycles) with data0=idx, data1=~idx -> the memory model contains the matching values at every address in 0..1151.
- Assert reset at accept #300 -> we0/we1/done go 0 immediately and addr1=576. A new start rewrites from addr0=0.
- start pulsed mid-WRITE at accept #50 -> no effect, addresses continue at 50. start in DONE -> done=0 the next cycle and the first write is at addr0=0.
